// File: rtl/transaction_router_nvc_pkg.sv
// ============================================================================
// transaction_router_nvc_pkg : shared types for the VC-to-destination router
// Revision 1.0
// ============================================================================
`default_nettype none

package transaction_router_nvc_pkg;

   typedef enum logic {
      ARB_PRIORITY    = 1'b0,
      ARB_ROUND_ROBIN = 1'b1
   } arb_mode_e;

   function automatic bit is_round_robin(input int mode);
      return mode == int'(ARB_ROUND_ROBIN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/transaction_router_nvc_if.sv
// ============================================================================
// transaction_router_nvc_if : ingress handshake and per-destination egress bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface transaction_router_nvc_if #(
   parameter int DATA_W   = 6,
   parameter int NUM_DEST = 2
);
   logic                       in_valid;
   logic [DATA_W-1:0]          in_data;
   logic                       in_ready;
   logic [NUM_DEST-1:0]        pop;
   logic [NUM_DEST*DATA_W-1:0] out_data;
   logic [NUM_DEST-1:0]        out_empty;
   logic [NUM_DEST-1:0]        out_aempty;

   modport master (
      output in_valid, in_data, pop,
      input  in_ready, out_data, out_empty, out_aempty
   );

   modport slave (
      input  in_valid, in_data, pop,
      output in_ready, out_data, out_empty, out_aempty
   );
endinterface

`default_nettype wire

// File: rtl/transaction_router_nvc_fifo.sv
// ============================================================================
// transaction_router_nvc_fifo : show-ahead RAM FIFO, thresholds, sticky error
// Revision 1.0
// ============================================================================
`default_nettype none

module transaction_router_nvc_fifo #(
   parameter int DATA_W = 6,
   parameter int AW     = 2
) (
   input  wire              clk,
   input  wire              reset_L,
   input  wire              push,
   input  wire              pop,
   input  wire [DATA_W-1:0] wdata,
   input  wire [AW:0]       afull_thr,
   input  wire [AW:0]       aempty_thr,
   output logic [DATA_W-1:0] rdata,
   output logic             empty,
   output logic             afull,
   output logic             aempty,
   output logic             err
);
   localparam int          DEPTH      = 1 << AW;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              full;
   logic              do_push;
   logic              do_pop;
   logic              bad_op;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign afull   = (count >= afull_thr);
   assign aempty  = (count <= aempty_thr);
   // A pop frees a slot in the same edge, so push into a full FIFO is legal then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign bad_op  = (pop & empty) | (push & full & ~do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bad_op) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/transaction_router_nvc.sv
// ============================================================================
// transaction_router_nvc : NUM_VC virtual-channel FIFOs arbitrated into NUM_DEST FIFOs
// Revision 1.0
// ============================================================================
`default_nettype none

module transaction_router_nvc
   import transaction_router_nvc_pkg::*;
#(
   parameter int DATA_W   = 6,
   parameter int NUM_VC   = 2,
   parameter int NUM_DEST = 2,
   parameter int VC_AW    = 3,
   parameter int D_AW     = 2,
   parameter int ARB_MODE = 0
) (
   input  wire               clk,
   input  wire               reset_L,
   input  wire               enable,
   input  wire [VC_AW:0]     vc_afull_thr,
   input  wire [D_AW:0]      d_afull_thr,
   input  wire [D_AW:0]      d_aempty_thr,
   transaction_router_nvc_if.slave bus,
   output logic              error,
   output logic              idle
);
   localparam int VC_ID_W   = $clog2(NUM_VC);
   localparam int DEST_ID_W = $clog2(NUM_DEST);
   localparam bit RR_MODE   = is_round_robin(ARB_MODE);

   logic [VC_ID_W-1:0]               in_vc;
   logic [NUM_VC-1:0]                vc_push;
   logic [NUM_VC-1:0]                vc_pop;
   logic [NUM_VC-1:0]                vc_empty;
   logic [NUM_VC-1:0]                vc_afull;
   logic [NUM_VC-1:0]                vc_aempty;
   logic [NUM_VC-1:0]                vc_err;
   logic [DATA_W-1:0]                vc_head [NUM_VC];
   logic [NUM_DEST-1:0]              d_empty;
   logic [NUM_DEST-1:0]              d_afull;
   logic [NUM_DEST-1:0]              d_err;
   logic [NUM_DEST-1:0][NUM_VC-1:0]  gnt;

   assign in_vc        = bus.in_data[DATA_W-1 -: VC_ID_W];
   assign bus.in_ready = reset_L & enable & ~vc_afull[in_vc];

   always_comb begin
      vc_push = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         vc_push[v] = bus.in_valid & bus.in_ready & (in_vc == VC_ID_W'(v));
      end
   end

   // Each VC has a single head, so at most one destination can grant it.
   always_comb begin
      vc_pop = '0;
      for (int d = 0; d < NUM_DEST; d++) begin
         vc_pop = vc_pop | gnt[d];
      end
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      // Almost-empty threshold tied to 0 makes aempty an exact empty flag for idle.
      transaction_router_nvc_fifo #(.DATA_W(DATA_W), .AW(VC_AW)) u_vc_fifo (
         .clk        (clk),
         .reset_L    (reset_L),
         .push       (vc_push[v]),
         .pop        (vc_pop[v]),
         .wdata      (bus.in_data),
         .afull_thr  (vc_afull_thr),
         .aempty_thr ('0),
         .rdata      (vc_head[v]),
         .empty      (vc_empty[v]),
         .afull      (vc_afull[v]),
         .aempty     (vc_aempty[v]),
         .err        (vc_err[v])
      );
   end

   for (genvar d = 0; d < NUM_DEST; d++) begin : g_arb
      logic [NUM_VC-1:0]  req_d;
      logic [NUM_VC-1:0]  gnt_d;
      logic [VC_ID_W-1:0] rr_ptr;
      logic [VC_ID_W-1:0] base;
      logic [VC_ID_W-1:0] cand;
      logic [VC_ID_W-1:0] gnt_idx;
      logic               found;
      logic [DATA_W-1:0]  rdata_d;

      always_comb begin
         req_d = '0;
         for (int v = 0; v < NUM_VC; v++) begin
            req_d[v] = enable & ~vc_empty[v] & ~d_afull[d] &
                       (vc_head[v][DATA_W-1-VC_ID_W -: DEST_ID_W] == DEST_ID_W'(d));
         end
      end

      // Search starts at rr_ptr in round-robin mode, at VC 0 for strict priority.
      always_comb begin
         gnt_d   = '0;
         gnt_idx = '0;
         found   = 1'b0;
         cand    = '0;
         base    = RR_MODE ? rr_ptr : '0;
         for (int i = 0; i < NUM_VC; i++) begin
            cand = base + VC_ID_W'(i);
            if (!found && req_d[cand]) begin
               found       = 1'b1;
               gnt_idx     = cand;
               gnt_d[cand] = 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            rr_ptr <= '0;
         end else if (RR_MODE && found) begin
            rr_ptr <= gnt_idx + 1'b1;
         end
      end

      assign gnt[d] = gnt_d;

      transaction_router_nvc_fifo #(.DATA_W(DATA_W), .AW(D_AW)) u_dest_fifo (
         .clk        (clk),
         .reset_L    (reset_L),
         .push       (found),
         .pop        (bus.pop[d] & enable),
         .wdata      (vc_head[gnt_idx]),
         .afull_thr  (d_afull_thr),
         .aempty_thr (d_aempty_thr),
         .rdata      (rdata_d),
         .empty      (d_empty[d]),
         .afull      (d_afull[d]),
         .aempty     (bus.out_aempty[d]),
         .err        (d_err[d])
      );

      assign bus.out_data[d*DATA_W +: DATA_W] = rdata_d;
   end

   assign bus.out_empty = d_empty;
   assign error         = (|vc_err) | (|d_err);
   assign idle          = (&vc_aempty) & (&d_empty);

endmodule

`default_nettype wire

// File: tb/tb_transaction_router_nvc.sv
// ============================================================================
// tb_transaction_router_nvc : vector table plus scoreboard bench, strict and RR instances
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_transaction_router_nvc;

   logic       clk;
   logic       reset_L;
   logic       enable;
   logic [3:0] vc_afull_thr;
   logic [2:0] d_afull_thr;
   logic [2:0] d_aempty_thr;
   logic       error0, idle0, error1, idle1;
   logic [1:0] pop_man0, pop_man1, drain0, drain1;

   int n_checks = 0;
   int n_fail   = 0;

   // Queue index = dut*2 + dest; dut0 is strict priority, dut1 round-robin.
   logic [5:0] sbq [4][$];

   transaction_router_nvc_if #(.DATA_W(6), .NUM_DEST(2)) bus0 ();
   transaction_router_nvc_if #(.DATA_W(6), .NUM_DEST(2)) bus1 ();

   assign bus0.pop = pop_man0 | (drain0 & ~bus0.out_empty);
   assign bus1.pop = pop_man1 | (drain1 & ~bus1.out_empty);

   transaction_router_nvc #(.ARB_MODE(0)) dut0 (
      .clk(clk), .reset_L(reset_L), .enable(enable), .vc_afull_thr(vc_afull_thr),
      .d_afull_thr(d_afull_thr), .d_aempty_thr(d_aempty_thr), .bus(bus0),
      .error(error0), .idle(idle0));

   transaction_router_nvc #(.ARB_MODE(1)) dut1 (
      .clk(clk), .reset_L(reset_L), .enable(enable), .vc_afull_thr(vc_afull_thr),
      .d_afull_thr(d_afull_thr), .d_aempty_thr(d_aempty_thr), .bus(bus1),
      .error(error1), .idle(idle1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic check_out(input int q, input logic [5:0] got);
      logic [5:0] exp;
      n_checks++;
      if (sbq[q].size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected q%0d: got %0h, required no word", q, got);
      end else begin
         exp = sbq[q].pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL sb_word q%0d: got %0h, required %0h", q, got, exp);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset_L && enable) begin
         for (int d = 0; d < 2; d++) begin
            if (bus0.pop[d] && !bus0.out_empty[d]) check_out(d, bus0.out_data[d*6 +: 6]);
            if (bus1.pop[d] && !bus1.out_empty[d]) check_out(2 + d, bus1.out_data[d*6 +: 6]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after an edge; the handshake is sampled at the following edge.
   task automatic send(input int dut, input logic [5:0] w, input bit track);
      if (dut == 0) begin
         bus0.in_valid = 1'b1; bus0.in_data = w;
      end else begin
         bus1.in_valid = 1'b1; bus1.in_data = w;
      end
      #1;
      chk("in_ready", 32'(dut == 0 ? bus0.in_ready : bus1.in_ready), 32'd1);
      if (track) sbq[dut*2 + int'(w[4])].push_back(w);
      step();
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
   endtask

   typedef struct {
      logic [5:0] word;
      int         dest;
      logic [5:0] exp_out;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{6'b0_0_0101, 0, 6'h05};
      vecs[1] = '{6'b0_1_1010, 1, 6'h1a};
      vecs[2] = '{6'b1_0_0011, 0, 6'h23};
      vecs[3] = '{6'b1_1_1111, 1, 6'h3f};
      vecs[4] = '{6'b0_0_0000, 0, 6'h00};

      reset_L = 1'b0; enable = 1'b1;
      vc_afull_thr = 4'd8; d_afull_thr = 3'd4; d_aempty_thr = 3'd1;
      pop_man0 = '0; pop_man1 = '0; drain0 = '0; drain1 = '0;
      bus0.in_valid = 1'b1; bus0.in_data = '0;
      bus1.in_valid = 1'b0; bus1.in_data = '0;

      #12;
      chk("rst_error",     32'(error0),          32'd0);
      chk("rst_idle",      32'(idle0),           32'd1);
      chk("rst_empty",     32'(bus0.out_empty),  32'h3);
      chk("rst_aempty",    32'(bus0.out_aempty), 32'h3);
      chk("rst_out_data",  32'(bus0.out_data),   32'h0);
      chk("rst_in_ready",  32'(bus0.in_ready),   32'd0);
      chk("rst_idle_rr",   32'(idle1),           32'd1);
      bus0.in_valid = 1'b0;
      step();
      reset_L = 1'b1;
      step();

      // Single-word transits: latency, routing and show-ahead data.
      for (int i = 0; i < 5; i++) begin
         send(0, vecs[i].word, 1'b1);
         chk("lat_edge1_empty", 32'(bus0.out_empty[vecs[i].dest]), 32'd1);
         chk("busy_not_idle",   32'(idle0), 32'd0);
         step();
         chk("lat_edge2_empty", 32'(bus0.out_empty[vecs[i].dest]), 32'd0);
         chk("show_ahead_data", 32'(bus0.out_data[vecs[i].dest*6 +: 6]), 32'(vecs[i].exp_out));
         pop_man0[vecs[i].dest] = 1'b1;
         step();
         pop_man0 = '0;
         chk("drained_idle", 32'(idle0), 32'd1);
      end

      // Back-to-back words on different VCs and destinations.
      send(0, 6'b0_1_0001, 1'b1);
      send(0, 6'b1_0_0010, 1'b1);
      step();
      chk("par_d1_data", 32'(bus0.out_data[11:6]), 32'h11);
      chk("par_d0_data", 32'(bus0.out_data[5:0]),  32'h22);
      pop_man0 = 2'b11;
      step();
      pop_man0 = '0;
      chk("par_idle", 32'(idle0), 32'd1);

      // Dest0 stalled at its almost-full level; VC1 keeps draining to dest1.
      d_afull_thr = 3'd2;
      drain0 = 2'b10;
      for (int i = 0; i < 4; i++) begin
         send(0, {2'b00, 4'(i + 1)}, 1'b1);
         if (i < 3) send(0, {2'b11, 4'(i + 8)}, 1'b1);
      end
      repeat (6) step();
      chk("stall_d1_empty",  32'(bus0.out_empty[1]),  32'd1);
      chk("stall_aempty_t1", 32'(bus0.out_aempty[0]), 32'd0);
      d_aempty_thr = 3'd2;
      #1;
      chk("stall_aempty_t2", 32'(bus0.out_aempty[0]), 32'd1);
      chk("stall_vc_held",   32'(idle0),  32'd0);
      chk("stall_no_error",  32'(error0), 32'd0);
      d_aempty_thr = 3'd1;
      drain0 = 2'b11;
      repeat (10) step();
      drain0 = '0;
      d_afull_thr = 3'd4;
      chk("stall_all_idle", 32'(idle0), 32'd1);
      chk("stall_sb_left",  32'(sbq[0].size() + sbq[1].size()), 32'd0);

      // Both VCs loaded with dest0 words while dest0 is blocked, then released.
      d_afull_thr = 3'd0;
      for (int i = 0; i < 8; i++) begin
         bus1.in_valid = 1'b1;
         bus1.in_data  = (i < 4) ? {2'b00, 4'(i)} : {2'b10, 4'(i + 4)};
         send(0, (i < 4) ? {2'b00, 4'(i)} : {2'b10, 4'(i + 4)}, 1'b0);
      end
      for (int i = 0; i < 4; i++) sbq[0].push_back({2'b00, 4'(i)});
      for (int i = 0; i < 4; i++) sbq[0].push_back({2'b10, 4'(i + 8)});
      for (int i = 0; i < 4; i++) begin
         sbq[2].push_back({2'b00, 4'(i)});
         sbq[2].push_back({2'b10, 4'(i + 8)});
      end
      step();
      chk("blocked_empty_prio", 32'(bus0.out_empty), 32'h3);
      chk("blocked_empty_rr",   32'(bus1.out_empty), 32'h3);
      chk("blocked_not_idle",   32'(idle1), 32'd0);
      d_afull_thr = 3'd4;
      drain0 = 2'b01;
      drain1 = 2'b01;
      repeat (16) step();
      drain0 = '0;
      drain1 = '0;
      chk("arb_prio_sb_left", 32'(sbq[0].size()), 32'd0);
      chk("arb_rr_sb_left",   32'(sbq[2].size()), 32'd0);
      chk("arb_rr_idle",      32'(idle1), 32'd1);

      // Illegal pop, sticky error, enable gating, then async reset mid-traffic.
      chk("err_before", 32'(error0), 32'd0);
      pop_man0 = 2'b10;
      step();
      pop_man0 = '0;
      chk("err_set", 32'(error0), 32'd1);
      repeat (2) step();
      chk("err_sticky", 32'(error0), 32'd1);
      enable = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.in_data  = 6'b0_0_0001;
      #1;
      chk("disabled_in_ready", 32'(bus0.in_ready), 32'd0);
      bus0.in_valid = 1'b0;
      enable = 1'b1;
      step();
      send(0, 6'b0_0_0110, 1'b1);
      send(0, 6'b1_1_0111, 1'b1);
      bus0.in_valid = 1'b1;
      bus0.in_data  = 6'b0_1_1000;
      #2;
      reset_L = 1'b0;
      #1;
      chk("arst_error",    32'(error0),          32'd0);
      chk("arst_idle",     32'(idle0),           32'd1);
      chk("arst_empty",    32'(bus0.out_empty),  32'h3);
      chk("arst_out_data", 32'(bus0.out_data),   32'h0);
      chk("arst_in_ready", 32'(bus0.in_ready),   32'd0);
      for (int q = 0; q < 4; q++) sbq[q].delete();
      bus0.in_valid = 1'b0;
      repeat (2) step();
      reset_L = 1'b1;
      step();
      chk("post_rst_idle", 32'(idle0), 32'd1);
      chk("final_sb_left",
          32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
